seg7_scan_controller: RTL

//  Time-multiplexed scan scheduler for the 3-digit 7-segment display.

---
 rtl/seg7_scan_if.sv | 28 ++
 rtl/seg7_scan_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Bundle of the value handshake, scan controls and digit-drive outputs
// exchanged between the scan controller and its surroundings.
interface seg7_scan_if #(
  parameter int NDIG = 3
);
  logic                enable;
  logic [4*NDIG-1:0]   val_in;
  logic                val_valid;
  logic                val_ready;
  logic [3:0]          bright;
  logic                lzb;
  logic [NDIG-1:0]     dig_en;
  logic [3:0]          code;
  logic                blank;
  logic                frame_done;

  // Source side: counter/value producer and scan configuration
  modport master (
    output enable, val_in, val_valid, bright, lzb,
    input  val_ready, dig_en, code, blank, frame_done
  );

  // Scan controller side
  modport slave (
    input  enable, val_in, val_valid, bright, lzb,
    output val_ready, dig_en, code, blank, frame_done
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan scheduler for a multi-digit 7-segment display.
// Each digit slot is a dead-time (all digits off) followed by an on-window
// whose length follows the brightness setting. Digit values are double
// buffered: a pending buffer takes new values via valid/ready and is
// copied to the active buffer only at frame boundaries (or while idle),
// so a frame never shows a mix of old and new digits.
module seg7_scan_controller #(
  parameter int NDIG     = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  seg7_scan_if.slave  bus
);

  localparam int PW   = $clog2(SCAN_DIV);
  localparam int SW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int STEP = (SCAN_DIV - DEAD) / 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEAD = 2'd1,
    S_ON   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_phase;
  logic [PW-1:0]     w_phase_nxt;
  logic [SW-1:0]     r_slot;
  logic [SW-1:0]     w_slot_nxt;
  logic              w_frame_done;

  logic [3:0]        r_bright;
  logic [4*NDIG-1:0] r_act;
  logic [4*NDIG-1:0] r_pend;
  logic              r_val_ready;
  logic              w_load;
  logic              w_commit;

  logic [NDIG-1:0]   r_dig_en;
  logic [3:0]        r_code;
  logic              r_blank;
  logic              r_frame_done;

  logic [NDIG-1:0]   w_blank_vec;
  logic              w_hi_zero;
  logic [3:0]        w_nib;
  logic              w_digit_blank;
  logic [PW+3:0]     w_ofs;
  logic [PW+3:0]     w_limit;
  logic              w_lit;
  logic [NDIG-1:0]   w_dig_en;
  logic [3:0]        w_code;

  // Scan FSM state, phase and slot registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_phase <= {PW{1'b0}};
      r_slot  <= {SW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Next-state logic: dead-time, on-window and slot/frame sequencing
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_slot_nxt   = r_slot;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = {PW{1'b0}};
        w_slot_nxt  = {SW{1'b0}};
        if (bus.enable) begin
          w_state_nxt = S_DEAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DEAD: begin
        w_phase_nxt = r_phase + PW'(1);
        if (r_phase == PW'(DEAD - 1)) begin
          w_state_nxt = S_ON;
        end else begin
          w_state_nxt = S_DEAD;
        end
      end
      S_ON: begin
        if (r_phase == PW'(SCAN_DIV - 1)) begin
          w_phase_nxt = {PW{1'b0}};
          if (r_slot == SW'(NDIG - 1)) begin
            w_slot_nxt   = {SW{1'b0}};
            w_frame_done = 1'b1;
          end else begin
            w_slot_nxt = r_slot + SW'(1);
          end
          // A disabled scan always restarts from slot 0 when re-enabled
          if (bus.enable) begin
            w_state_nxt = S_DEAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_slot_nxt  = {SW{1'b0}};
          end
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = {PW{1'b0}};
        w_slot_nxt  = {SW{1'b0}};
      end
    endcase
  end

  // Latch brightness on entry to the on-window so a slot never changes duty midway
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bright <= 4'd0;
    end else if ((r_state == S_DEAD) && (w_state_nxt == S_ON)) begin
      r_bright <= bus.bright;
    end else begin
      r_bright <= r_bright;
    end
  end

  // Select the active nibble of the current slot and its leading-zero blanking
  always_comb begin
    w_hi_zero      = 1'b1;
    w_blank_vec    = {NDIG{1'b0}};
    w_nib          = 4'd0;
    w_digit_blank  = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      w_hi_zero      = w_hi_zero & (r_act[4*i +: 4] == 4'd0);
      w_blank_vec[i] = bus.lzb & w_hi_zero;
    end
    for (int i = 0; i < NDIG; i++) begin
      w_nib         = (r_slot == SW'(i)) ? r_act[4*i +: 4] : w_nib;
      w_digit_blank = (r_slot == SW'(i)) ? w_blank_vec[i]  : w_digit_blank;
    end
  end

  // On-window test and next digit-enable/code values
  always_comb begin
    w_ofs    = {4'd0, r_phase} - (PW+4)'(DEAD);
    w_limit  = {{PW{1'b0}}, r_bright} * (PW+4)'(STEP);
    w_lit    = (r_state == S_ON) && (w_ofs < w_limit) && !w_digit_blank;
    w_dig_en = {NDIG{1'b0}};
    for (int i = 0; i < NDIG; i++) begin
      w_dig_en[i] = w_lit && (r_slot == SW'(i));
    end
    if (w_lit) begin
      w_code = w_nib;
    end else begin
      w_code = 4'd0;
    end
  end

  // Registered display outputs: enable, code and blank move together
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dig_en     <= {NDIG{1'b0}};
      r_code       <= 4'd0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_dig_en     <= w_dig_en;
      r_code       <= w_code;
      r_blank      <= (w_dig_en == {NDIG{1'b0}});
      r_frame_done <= w_frame_done;
    end
  end

  // Commit happens during the frame-done cycle or continuously while idle;
  // copying an already-committed pending buffer is harmless.
  assign w_load   = bus.val_valid & r_val_ready;
  assign w_commit = r_frame_done | (r_state == S_IDLE);

  // Pending/active double buffer and the ready flag of the value handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend      <= {(4*NDIG){1'b0}};
      r_act       <= {(4*NDIG){1'b0}};
      r_val_ready <= 1'b1;
    end else begin
      if (w_commit) begin
        r_act <= r_pend;
      end else begin
        r_act <= r_act;
      end
      if (w_load) begin
        r_pend      <= bus.val_in;
        r_val_ready <= 1'b0;
      end else if (w_commit) begin
        r_val_ready <= 1'b1;
      end else begin
        r_val_ready <= r_val_ready;
      end
    end
  end

  assign bus.dig_en     = r_dig_en;
  assign bus.code       = r_code;
  assign bus.blank      = r_blank;
  assign bus.frame_done = r_frame_done;
  assign bus.val_ready  = r_val_ready;

endmodule
